// File: rtl/pipelined_shifter_pkg.sv
// pipelined_shifter_pkg: mode encodings and elaboration-time helpers shared by the shifter files
package pipelined_shifter_pkg;

    typedef enum logic [1:0] {
        MODE_SLL = 2'b00,
        MODE_SRL = 2'b01,
        MODE_SRA = 2'b10,
        MODE_ROR = 2'b11
    } mode_e;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < v) r = i + 1;
        return r;
    endfunction

endpackage

// File: rtl/pipelined_shifter_shift_stage.sv
// shift_stage: one registered barrel-shifter stage applying a shift of 2^K when amount bit K is set
module shift_stage
    import pipelined_shifter_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int K     = 0,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             adv_i,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic [AW-1:0]    amt_i,
    input  mode_e            mode_i,
    input  logic             ovr_i,
    input  logic             sign_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o,
    output logic [AW-1:0]    amt_o,
    output mode_e            mode_o,
    output logic             ovr_o,
    output logic             sign_o
);

    localparam int S = 1 << K;

    logic [WIDTH-1:0] data_d, data_q;
    logic [AW-1:0]    amt_q;
    logic             valid_q, ovr_q, sign_q;
    mode_e            mode_q;

    assign data_d = !amt_i[K]            ? data_i :
                    mode_i == MODE_SLL   ? {data_i[WIDTH-1-S:0], {S{1'b0}}} :
                    mode_i == MODE_SRL   ? {{S{1'b0}}, data_i[WIDTH-1:S]} :
                    mode_i == MODE_SRA   ? {{S{data_i[WIDTH-1]}}, data_i[WIDTH-1:S]} :
                                           {data_i[S-1:0], data_i[WIDTH-1:S]};

    // Everything holds together when the output is stalled, so bubbles stay in place
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            amt_q   <= '0;
            mode_q  <= MODE_SLL;
            ovr_q   <= 1'b0;
            sign_q  <= 1'b0;
        end else if (adv_i) begin
            valid_q <= valid_i;
            data_q  <= data_d;
            amt_q   <= amt_i;
            mode_q  <= mode_i;
            ovr_q   <= ovr_i;
            sign_q  <= sign_i;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign amt_o   = amt_q;
    assign mode_o  = mode_q;
    assign ovr_o   = ovr_q;
    assign sign_o  = sign_q;

endmodule

// File: rtl/pipelined_shifter.sv
// pipelined_shifter: valid/ready barrel shifter (SLL/SRL/SRA/ROR) with one stage per amount bit
// and a registered output fix-up for over-range amounts.
module pipelined_shifter
    import pipelined_shifter_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int AMT_W = 8
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] IN_DATA,
    input  logic [AMT_W-1:0] SHIFT_AMT,
    input  logic [1:0]       MODE,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] OUT_DATA,
    output logic             OUT_ZERO
);

    localparam int LAT = clog2(WIDTH);

    logic             adv;
    logic             valid_p [LAT+1];
    logic [WIDTH-1:0] data_p  [LAT+1];
    logic [LAT-1:0]   amt_p   [LAT+1];
    mode_e            mode_p  [LAT+1];
    logic             ovr_p   [LAT+1];
    logic             sign_p  [LAT+1];
    logic [WIDTH-1:0] out_data_d, out_data_q;
    logic             out_valid_q;

    assign adv      = !(out_valid_q && !OUT_READY);
    assign IN_READY = adv;

    // Only the low amount bits drive the stages; anything larger is flagged here
    assign valid_p[0] = IN_VALID;
    assign data_p[0]  = IN_DATA;
    assign amt_p[0]   = SHIFT_AMT[LAT-1:0];
    assign mode_p[0]  = mode_e'(MODE);
    assign ovr_p[0]   = SHIFT_AMT >= AMT_W'(WIDTH);
    assign sign_p[0]  = IN_DATA[WIDTH-1];

    for (genvar k = 0; k < LAT; k++) begin : g_stage
        shift_stage #(.WIDTH(WIDTH), .K(k), .AW(LAT)) u_stage (
            .clk     (CLK),
            .rst_n   (RESET),
            .adv_i   (adv),
            .valid_i (valid_p[k]),
            .data_i  (data_p[k]),
            .amt_i   (amt_p[k]),
            .mode_i  (mode_p[k]),
            .ovr_i   (ovr_p[k]),
            .sign_i  (sign_p[k]),
            .valid_o (valid_p[k+1]),
            .data_o  (data_p[k+1]),
            .amt_o   (amt_p[k+1]),
            .mode_o  (mode_p[k+1]),
            .ovr_o   (ovr_p[k+1]),
            .sign_o  (sign_p[k+1])
        );
    end

    // ROR already wrapped modulo WIDTH, so over-range only overrides the other modes
    assign out_data_d = !ovr_p[LAT] || mode_p[LAT] == MODE_ROR ? data_p[LAT] :
                        mode_p[LAT] == MODE_SRA                ? {WIDTH{sign_p[LAT]}} : '0;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else if (adv) begin
            out_valid_q <= valid_p[LAT];
            out_data_q  <= out_data_d;
        end
    end

    assign OUT_VALID = out_valid_q;
    assign OUT_DATA  = out_data_q;
    assign OUT_ZERO  = out_data_q == '0;

endmodule

// File: tb/tb_pipelined_shifter.sv
// tb_pipelined_shifter: directed checks of latency, modes, over-range, stall, throughput and reset
module tb_pipelined_shifter;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic [7:0] shift_amt;
    logic [1:0] mode;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_zero;

    int checks = 0;
    int errors = 0;

    pipelined_shifter #(.WIDTH(8), .AMT_W(8)) dut (
        .CLK       (clk),
        .RESET     (rst_n),
        .IN_VALID  (in_valid),
        .IN_READY  (in_ready),
        .IN_DATA   (in_data),
        .SHIFT_AMT (shift_amt),
        .MODE      (mode),
        .OUT_VALID (out_valid),
        .OUT_READY (out_ready),
        .OUT_DATA  (out_data),
        .OUT_ZERO  (out_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] ref_shift(input logic [7:0] d, input logic [7:0] a, input logic [1:0] m);
        int s;
        s = int'(a) % 8;
        if (a >= 8 && m != 2'b11) return m == 2'b10 ? {8{d[7]}} : 8'h00;
        case (m)
            2'b00:   return d << s;
            2'b01:   return d >> s;
            2'b10:   return 8'($signed(d) >>> s);
            default: return (d >> s) | (d << (8 - s));
        endcase
    endfunction

    task automatic drive(input logic [7:0] d, input logic [7:0] a, input logic [1:0] m);
        in_data   = d;
        shift_amt = a;
        mode      = m;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        shift_amt = '0;
        mode = '0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", out_valid); end
        checks++;
        if (out_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", out_data); end
        checks++;
        if (out_zero !== 1'b1) begin errors++; $display("FAIL reset_zero got %b want 1", out_zero); end
        rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_latency;
        drive(8'h81, 8'd1, 2'b00);
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL latency_early got %b want 0", out_valid); end
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL latency_valid got %b want 1", out_valid); end
        checks++;
        if (out_data !== 8'h02) begin errors++; $display("FAIL latency_data got %h want 02", out_data); end
        checks++;
        if (out_zero !== 1'b0) begin errors++; $display("FAIL latency_zero got %b want 0", out_zero); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_modes;
        logic [7:0] vd [8] = '{8'h90, 8'h80, 8'hFF, 8'h81, 8'h81, 8'h81, 8'h81, 8'h81};
        logic [7:0] va [8] = '{8'd2, 8'd200, 8'd8, 8'd9, 8'd0, 8'd0, 8'd0, 8'd0};
        logic [1:0] vm [8] = '{2'b10, 2'b10, 2'b01, 2'b11, 2'b11, 2'b00, 2'b01, 2'b10};
        logic [7:0] ve [8] = '{8'hE4, 8'hFF, 8'h00, 8'hC0, 8'h81, 8'h81, 8'h81, 8'h81};
        for (int i = 0; i < 8; i++) begin
            drive(vd[i], va[i], vm[i]);
            repeat (3) @(posedge clk);
            #1;
            checks++;
            if (out_valid !== 1'b1 || out_data !== ve[i])
                begin errors++; $display("FAIL mode_vec%0d got v=%b d=%h want v=1 d=%h", i, out_valid, out_data, ve[i]); end
            checks++;
            if (out_zero !== (ve[i] == 8'h00))
                begin errors++; $display("FAIL mode_zero%0d got %b want %b", i, out_zero, ve[i] == 8'h00); end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back_stall;
        logic [7:0] vd [3] = '{8'h0F, 8'hF0, 8'h12};
        logic [7:0] va [3] = '{8'd4, 8'd3, 8'd4};
        logic [1:0] vm [3] = '{2'b00, 2'b01, 2'b11};
        logic [7:0] ve [3] = '{8'hF0, 8'h1E, 8'h21};
        for (int i = 0; i < 3; i++) begin
            in_data = vd[i];
            shift_amt = va[i];
            mode = vm[i];
            in_valid = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== ve[0] || in_ready !== 1'b0)
                begin errors++; $display("FAIL stall_hold%0d got v=%b d=%h rdy=%b want v=1 d=%h rdy=0", i, out_valid, out_data, in_ready, ve[0]); end
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        for (int i = 1; i < 3; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (out_valid !== 1'b1 || out_data !== ve[i])
                begin errors++; $display("FAIL stall_order%0d got v=%b d=%h want v=1 d=%h", i, out_valid, out_data, ve[i]); end
        end
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL stall_drain got %b want 0", out_valid); end
    endtask

    task automatic test_throughput;
        logic [7:0] exp_q[$];
        logic [7:0] d, a, e;
        logic [1:0] m;
        int got;
        got = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (i < 10) begin
                d = 8'($urandom);
                a = 8'($urandom_range(0, 15));
                m = 2'($urandom);
                in_data = d;
                shift_amt = a;
                mode = m;
                in_valid = 1'b1;
                checks++;
                if (in_ready !== 1'b1) begin errors++; $display("FAIL tput_ready%0d got %b want 1", i, in_ready); end
                exp_q.push_back(ref_shift(d, a, m));
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk);
            #1;
            if (out_valid === 1'b1) begin
                e = exp_q.size() > 0 ? exp_q.pop_front() : 8'hxx;
                checks++;
                if (out_data !== e) begin errors++; $display("FAIL tput_data%0d got %h want %h", got, out_data, e); end
                got++;
            end
        end
        checks++;
        if (got != 10) begin errors++; $display("FAIL tput_count got %0d want 10", got); end
    endtask

    task automatic test_reset_inflight;
        drive(8'h33, 8'd1, 2'b00);
        drive(8'h44, 8'd2, 2'b01);
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_inflight_valid got %b want 0", out_valid); end
        checks++;
        if (out_data !== 8'h00 || out_zero !== 1'b1)
            begin errors++; $display("FAIL rst_inflight_data got d=%h z=%b want d=00 z=1", out_data, out_zero); end
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_stale%0d got %b want 0", i, out_valid); end
        end
        drive(8'h01, 8'd7, 2'b00);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h80)
            begin errors++; $display("FAIL rst_after got v=%b d=%h want v=1 d=80", out_valid, out_data); end
        @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset;
        test_latency;
        test_modes;
        test_back_to_back_stall;
        test_throughput;
        test_reset_inflight;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
